// File: rtl/gray_hsmooth3.sv
// gray_hsmooth3 -- horizontal [1 2 1]/4 smoothing filter on a gray pixel stream.
//
// Rows are delimited by last_i. The first and last pixels of each row are
// replicated, so every input pixel produces exactly one output pixel. The
// final output of a row carries last_o.
//
// Ports
//   clk_i     clock
//   reset_ni  asynchronous active-low reset
//   valid_i   upstream gray pixel valid
//   gray_i    upstream gray pixel
//   last_i    gray_i is the final pixel of its row
//   ready_o   block accepts gray_i this cycle
//   valid_o   smoothed pixel valid
//   gray_o    smoothed pixel
//   last_o    gray_o is the final pixel of its row
//   ready_i   downstream accepts gray_o
module gray_hsmooth3 #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  input  logic [width_p-1:0] gray_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] gray_o,
  output logic               last_o,
  input  logic               ready_i
);

  typedef enum logic [1:0] {
    EMPTY,
    HAVE,
    FLUSH
  } state_e;

  localparam logic [width_p+1:0] RoundC = (width_p+2)'(2);

  state_e             state_q, state_d;
  logic [width_p-1:0] prev_q, prev_d;
  logic [width_p-1:0] cur_q, cur_d;

  logic               slot_free;
  logic               in_xfer;
  logic               load;
  logic               load_last;
  logic [width_p-1:0] tap_c;
  logic [width_p+1:0] sum;
  logic [width_p-1:0] load_gray;

  assign slot_free = ~valid_o | ready_i;

  always_comb begin
    ready_o = 1'b0;
    unique case (state_q)
      EMPTY:   ready_o = 1'b1;
      HAVE:    ready_o = slot_free;
      FLUSH:   ready_o = 1'b0;
      default: ready_o = 1'b0;
    endcase
  end

  assign in_xfer = valid_i & ready_o;

  // The third tap is the new pixel while streaming and the replicated
  // current pixel when closing the row.
  assign tap_c     = (state_q == FLUSH) ? cur_q : gray_i;
  assign sum       = {2'b00, prev_q} + {1'b0, cur_q, 1'b0} + {2'b00, tap_c} + RoundC;
  assign load_gray = sum[width_p+1:2];

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    load      = 1'b0;
    load_last = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          prev_d  = gray_i;
          cur_d   = gray_i;
          state_d = last_i ? FLUSH : HAVE;
        end
      end
      HAVE: begin
        if (in_xfer) begin
          load    = 1'b1;
          prev_d  = cur_q;
          cur_d   = gray_i;
          state_d = last_i ? FLUSH : HAVE;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load      = 1'b1;
          load_last = 1'b1;
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= EMPTY;
      prev_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      gray_o  <= '0;
      last_o  <= 1'b0;
    end else if (load) begin
      valid_o <= 1'b1;
      gray_o  <= load_gray;
      last_o  <= load_last;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_hsmooth3.sv
// tb_gray_hsmooth3 -- directed and randomised bench for gray_hsmooth3.
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge.
module tb_gray_hsmooth3;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       valid_i;
  logic [7:0] gray_i;
  logic       last_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] gray_o;
  logic       last_o;
  logic       ready_i;

  int checks = 0;
  int errors = 0;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  bit         rand_rdy = 1'b0;

  always #5 clk_i = ~clk_i;

  gray_hsmooth3 #(.width_p(8)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .gray_i   (gray_i),
    .last_i   (last_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .gray_o   (gray_o),
    .last_o   (last_o),
    .ready_i  (ready_i)
  );

  // Record every output transfer as {last, gray}.
  always @(negedge clk_i) begin
    if (valid_o && ready_i) obs_q.push_back({last_o, gray_o});
  end

  always @(posedge clk_i) begin
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic l, input int gap);
    bit done;
    for (int g = 0; g < gap; g++) begin
      valid_i = 1'b0;
      gray_i  = 8'($urandom);
      last_i  = 1'($urandom);
      tick();
    end
    valid_i = 1'b1;
    gray_i  = x;
    last_i  = l;
    done    = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk_i);
      if (ready_o) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_accept got no accept expected accept of %0d", x);
    end
    valid_i = 1'b0;
    gray_i  = 8'($urandom);
    last_i  = 1'($urandom);
  endtask

  task automatic wait_outputs(input int n, input string name);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
    repeat (4) tick();
    checks++;
    if (obs_q.size() != n) begin
      errors++;
      $display("FAIL %s_count got %0d expected %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic model_row(input logic [7:0] row[8], input int n);
    int a, b, c;
    for (int i = 0; i < n; i++) begin
      a = int'(row[(i > 0) ? i - 1 : 0]);
      b = int'(row[i]);
      c = int'(row[(i < n - 1) ? i + 1 : n - 1]);
      exp_q.push_back({(i == n - 1), 8'((a + 2 * b + c + 2) / 4)});
    end
  endtask

  task automatic test_reset();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid_o); end
    checks++;
    if (gray_o !== 8'd0) begin errors++; $display("FAIL reset_gray got %0d expected 0", gray_o); end
    checks++;
    if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b expected 0", last_o); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", ready_o); end
  endtask

  task automatic test_basic_row();
    logic [8:0] exp[3];
    exp = '{9'h00D, 9'h014, 9'h11C};  // 13, 20, 28(last)
    obs_q.delete();
    send(8'd10, 1'b0, 0);
    send(8'd20, 1'b0, 0);
    send(8'd30, 1'b1, 0);
    wait_outputs(3, "basic");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_px%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1FF, exp[i]);
      end
    end
  endtask

  task automatic test_single_pixel();
    int low;
    obs_q.delete();
    send(8'd200, 1'b1, 0);
    low = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (!ready_o) low++;
      tick();
    end
    checks++;
    if (low != 1) begin errors++; $display("FAIL single_ready_low got %0d expected 1", low); end
    wait_outputs(1, "single");
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== 9'h1C8) begin
      errors++;
      $display("FAIL single_px got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 9'h1FF, 9'h1C8);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp[4];
    exp = '{9'h000, 9'h101, 9'h0FF, 9'h1FF};  // 0, 1(last), 255, 255(last)
    obs_q.delete();
    send(8'd0,   1'b0, 0);
    send(8'd1,   1'b1, 0);
    send(8'd255, 1'b0, 0);
    send(8'd255, 1'b1, 0);
    wait_outputs(4, "b2b");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_px%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1FF, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] exp[4];
    exp = '{9'h00D, 9'h014, 9'h01E, 9'h126};  // 13, 20, 30, 38(last)
    obs_q.delete();
    send(8'd10, 1'b0, 0);
    send(8'd20, 1'b0, 0);
    ready_i = 1'b0;
    valid_i = 1'b1;
    gray_i  = 8'd30;
    last_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b expected 1", i, valid_o); end
      checks++;
      if (gray_o !== 8'd13) begin errors++; $display("FAIL stall_gray%0d got %0d expected 13", i, gray_o); end
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b expected 0", i, ready_o); end
      tick();
    end
    ready_i = 1'b1;
    send(8'd30, 1'b0, 0);
    send(8'd40, 1'b1, 0);
    wait_outputs(4, "stall");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL stall_px%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 9'h1FF, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midrow();
    obs_q.delete();
    send(8'd50, 1'b0, 0);
    send(8'd60, 1'b0, 0);
    reset_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b expected 0", valid_o); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b expected 1", ready_o); end
    #2;
    reset_ni = 1'b1;
    tick();
    send(8'd7, 1'b1, 0);
    wait_outputs(1, "midreset");
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== 9'h107) begin
      errors++;
      $display("FAIL midreset_px got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 9'h1FF, 9'h107);
    end
  endtask

  task automatic test_random_rows();
    logic [7:0] row[8];
    int n, gap, bad, first_bad;
    obs_q.delete();
    exp_q.delete();
    rand_rdy = 1'b1;
    for (int r = 0; r < 1000; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) row[i] = 8'($urandom);
      for (int i = 0; i < n; i++) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        send(row[i], (i == n - 1), gap);
      end
      model_row(row, n);
    end
    wait_outputs(exp_q.size(), "random");
    rand_rdy = 1'b0;
    ready_i  = 1'b1;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_seq got %0d differing outputs (first at %0d) expected 0", bad, first_bad);
    end
  endtask

  initial begin
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    gray_i   = '0;
    last_i   = 1'b0;
    ready_i  = 1'b1;
    repeat (2) tick();
    test_reset();
    reset_ni = 1'b1;
    tick();
    test_basic_row();
    test_single_pixel();
    test_back_to_back();
    test_stall();
    test_reset_midrow();
    test_random_rows();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
